// File: rtl/panel_pago_pkg.sv
// panel_pago_pkg: shared state encoding, parameter defaults and service costs for the payment panel
package panel_pago_pkg;
    typedef enum logic [1:0] {IDLE, COBRO, FINAL, LIMPIAR} estado_t;
    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_MAX_CREDITO  = 15;
    localparam int DEF_HOLD_CYC     = 6;
    localparam int COSTE_CORTO      = 3;
    localparam int COSTE_NORMAL     = 4;
    localparam int COSTE_LARGO      = 9;
    function automatic logic [4:0] coste_servicio(input logic [1:0] sel);
        return (sel == 2'd0) ? 5'(COSTE_CORTO) : (sel == 2'd1) ? 5'(COSTE_NORMAL) : 5'(COSTE_LARGO);
    endfunction
endpackage

// File: rtl/panel_pago_antirrebote.sv
// panel_pago_antirrebote: 2-flop synchronizer, debounce counter and registered rising-edge event
module panel_pago_antirrebote
    import panel_pago_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic RESET_N,
    input  logic entrada,
    output logic evento
);
    logic sync1, sync2, nivel, nivel_d, cambia, listo;
    logic [3:0] cnt;
    assign cambia = sync2 != nivel;
    assign listo  = cnt == 4'(DEBOUNCE_CYC - 1);
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= 4'd0;
            nivel   <= 1'b0;
            nivel_d <= 1'b0;
            evento  <= 1'b0;
        end else begin
            sync1   <= entrada;
            sync2   <= sync1;
            cnt     <= (cambia && !listo) ? cnt + 4'd1 : 4'd0;
            nivel   <= (cambia && listo) ? sync2 : nivel;
            nivel_d <= nivel;
            evento  <= nivel & ~nivel_d;
        end
    end
endmodule

// File: rtl/panel_pago.sv
// panel_pago: conditions coin/finish inputs and runs the credit FSM that drives the washer controller
module panel_pago
    import panel_pago_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int MAX_CREDITO  = DEF_MAX_CREDITO,
    parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       SENSOR_MONEDA,
    input  logic       BOTON_FINALIZAR,
    output logic       INTRO_MONEDA,
    output logic       FINALIZAR_PAGO,
    output logic       RESET,
    output logic       RECHAZO,
    output logic [4:0] CREDITO,
    output logic       OCUPADO
);
    estado_t estado, estado_sig;
    logic ev_moneda, ev_boton, pendiente, abierto, acepta;
    logic [7:0] hold_cnt;
    panel_pago_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_moneda (
        .clk(clk), .RESET_N(RESET_N), .entrada(SENSOR_MONEDA), .evento(ev_moneda)
    );
    panel_pago_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_boton (
        .clk(clk), .RESET_N(RESET_N), .entrada(BOTON_FINALIZAR), .evento(ev_boton)
    );
    assign abierto = (estado == IDLE) || (estado == COBRO);
    // a pending finish locks out further coins so INTRO_MONEDA can never overlap FINAL
    assign acepta  = ev_moneda && abierto && !pendiente && (CREDITO < 5'(MAX_CREDITO));
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) estado <= IDLE;
        else          estado <= estado_sig;
    end
    always_comb begin
        estado_sig = abierto ? ((pendiente || (ev_boton && !ev_moneda)) ? FINAL : acepta ? COBRO : estado)
                   : (estado == FINAL) ? ((hold_cnt == 8'(HOLD_CYC - 1)) ? LIMPIAR : FINAL)
                   : IDLE;
    end
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pendiente    <= 1'b0;
            hold_cnt     <= 8'd0;
            CREDITO      <= 5'd0;
            INTRO_MONEDA <= 1'b0;
            RECHAZO      <= 1'b0;
        end else begin
            pendiente    <= abierto && !pendiente && ev_boton && ev_moneda;
            hold_cnt     <= (estado == FINAL) ? hold_cnt + 8'd1 : 8'd0;
            CREDITO      <= (estado == LIMPIAR) ? 5'd0 : acepta ? CREDITO + 5'd1 : CREDITO;
            INTRO_MONEDA <= acepta;
            RECHAZO      <= ev_moneda && !acepta;
        end
    end
    always_comb begin
        FINALIZAR_PAGO = estado == FINAL;
        RESET          = estado == LIMPIAR;
        OCUPADO        = (estado == FINAL) || (estado == LIMPIAR);
    end
endmodule
